// File: rtl/sap1_mac.sv
// sap1_mac -- multi-cycle multiply-accumulate unit for the SAP-1 datapath.
//
// Operands are captured from the shared bus (REGA/REGB). A run opcode
// (MUL/MAC/MSUB) snapshots them and runs a radix-2 shift-add multiply for
// DATA_WIDTH cycles. One ACCUM cycle then folds the product into a
// 2*DATA_WIDTH accumulator. MSW/LSW copy either half of ACC into mac_out.
//
// Build option: define SAP1_MAC_SIGNED_EN for a two's-complement multiply
// with signed overflow detection. When it is undefined the multiply is
// unsigned and overflow means carry (MAC) or borrow (MSUB).
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high reset
//   mac_opcode    4-bit command, valid for one cycle
//   bus_in        shared data bus, sampled on REGA/REGB
//   mac_out       output register feeding the bus mux
//   mac_busy      high in the MULT and ACCUM cycles
//   mac_done      one-cycle pulse in the cycle ACC is written
//   mac_zero      combinational ACC == 0
//   mac_overflow  sticky overflow flag, cleared by MUL or by reset
module sap1_mac #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            mac_opcode,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] mac_out,
  output logic                  mac_busy,
  output logic                  mac_done,
  output logic                  mac_zero,
  output logic                  mac_overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [3:0] OP_MUL  = 4'd1;
  localparam logic [3:0] OP_MAC  = 4'd2;
  localparam logic [3:0] OP_MSUB = 4'd3;
  localparam logic [3:0] OP_REGA = 4'd4;
  localparam logic [3:0] OP_REGB = 4'd5;
  localparam logic [3:0] OP_MSW  = 4'd6;
  localparam logic [3:0] OP_LSW  = 4'd7;
  localparam logic [3:0] OP_RST  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_ACCUM} state_t;

  state_t          state;
  logic [W-1:0]    a_reg, b_reg;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [AW-1:0]   partial;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;

  logic            run_req;
  logic            last_step;
  logic [AW-1:0]   part_nxt;
  logic [AW:0]     sum_ext, dif_ext;
  logic            add_ovf, sub_ovf;
  logic [AW-1:0]   mcand_init;

  assign run_req   = (mac_opcode == OP_MUL) || (mac_opcode == OP_MAC) ||
                     (mac_opcode == OP_MSUB);
  assign last_step = (cnt == CW'(1));
  assign mac_zero  = (acc == '0);

`ifdef SAP1_MAC_SIGNED_EN
  assign mcand_init = {{W{a_reg[W-1]}}, a_reg};
`else
  assign mcand_init = {{W{1'b0}}, a_reg};
`endif

  // One shift-add step. In the signed build the multiplier MSB carries
  // negative weight, so on the last step its term is subtracted.
  always_comb begin
    part_nxt = partial;
    if (mplier[0]) begin
`ifdef SAP1_MAC_SIGNED_EN
      if (last_step) part_nxt = partial - mcand;
      else           part_nxt = partial + mcand;
`else
      part_nxt = partial + mcand;
`endif
    end
  end

  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, partial};
    dif_ext = {1'b0, acc} - {1'b0, partial};
`ifdef SAP1_MAC_SIGNED_EN
    // Signed overflow: result sign differs from what the operand signs allow.
    add_ovf = (acc[AW-1] == partial[AW-1]) && (sum_ext[AW-1] != acc[AW-1]);
    sub_ovf = (acc[AW-1] != partial[AW-1]) && (dif_ext[AW-1] != acc[AW-1]);
`else
    add_ovf = sum_ext[AW];
    sub_ovf = dif_ext[AW];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || (mac_opcode == OP_RST)) begin
      state        <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      partial      <= '0;
      cnt          <= '0;
      op_q         <= '0;
      mac_out      <= '0;
      mac_busy     <= 1'b0;
      mac_done     <= 1'b0;
      mac_overflow <= 1'b0;
    end else begin
      // Register loads and readouts are legal in every state. The running
      // multiply works from its own snapshot, and a readout in the ACCUM
      // cycle sees the ACC value from before the update.
      case (mac_opcode)
        OP_REGA: a_reg   <= bus_in;
        OP_REGB: b_reg   <= bus_in;
        OP_MSW:  mac_out <= acc[AW-1:W];
        OP_LSW:  mac_out <= acc[W-1:0];
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (run_req) begin
            mcand    <= mcand_init;
            mplier   <= b_reg;
            partial  <= '0;
            cnt      <= CW'(W);
            op_q     <= mac_opcode[1:0];
            mac_busy <= 1'b1;
            state    <= S_MULT;
          end
        end
        S_MULT: begin
          partial <= part_nxt;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          cnt     <= cnt - CW'(1);
          if (last_step) begin
            state    <= S_ACCUM;
            mac_done <= 1'b1;
          end
        end
        S_ACCUM: begin
          case (op_q)
            2'd1: begin
              acc          <= partial;
              mac_overflow <= 1'b0;
            end
            2'd2: begin
              acc <= sum_ext[AW-1:0];
              if (add_ovf) mac_overflow <= 1'b1;
            end
            2'd3: begin
              acc <= dif_ext[AW-1:0];
              if (sub_ovf) mac_overflow <= 1'b1;
            end
            default: ;
          endcase
          mac_done <= 1'b0;
          mac_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_mac.sv
module tb_sap1_mac;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   mac_opcode = 4'd0;
  logic [W-1:0] bus_in = '0;
  logic [W-1:0] mac_out;
  logic         mac_busy, mac_done, mac_zero, mac_overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0]   a_m, b_m, out_m;
  logic [2*W-1:0] acc_m;
  logic           ovf_m;

  sap1_mac #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .mac_opcode(mac_opcode), .bus_in(bus_in),
    .mac_out(mac_out), .mac_busy(mac_busy), .mac_done(mac_done),
    .mac_zero(mac_zero), .mac_overflow(mac_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
`ifdef SAP1_MAC_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[2*W-1:0];
  endfunction

  // Apply a completed run op to the model using integer arithmetic.
  task automatic model_run(input logic [3:0] op, input logic [2*W-1:0] p);
    int s;
    case (op)
      4'd1: begin acc_m = p; ovf_m = 1'b0; end
      4'd2, 4'd3: begin
`ifdef SAP1_MAC_SIGNED_EN
        s = (op == 4'd2) ? int'($signed(acc_m)) + int'($signed(p))
                         : int'($signed(acc_m)) - int'($signed(p));
        if (s > 32767 || s < -32768) ovf_m = 1'b1;
`else
        s = (op == 4'd2) ? int'(acc_m) + int'(p) : int'(acc_m) - int'(p);
        if (s > 65535 || s < 0) ovf_m = 1'b1;
`endif
        acc_m = s[2*W-1:0];
      end
      default: ;
    endcase
  endtask

  task automatic model_simple(input logic [3:0] op, input logic [W-1:0] d);
    case (op)
      4'd4: a_m = d;
      4'd5: b_m = d;
      4'd6: out_m = acc_m[2*W-1:W];
      4'd7: out_m = acc_m[W-1:0];
      default: ;
    endcase
  endtask

  task automatic model_reset();
    a_m = '0; b_m = '0; acc_m = '0; out_m = '0; ovf_m = 1'b0;
  endtask

  // Single-cycle opcode; returns #1 after the edge that consumed it.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] d);
    mac_opcode = op; bus_in = d;
    @(posedge clk); #1;
    mac_opcode = 4'd0;
    if (op == 4'd8) model_reset(); else model_simple(op, d);
  endtask

  // Run opcode with an optional injected opcode during busy cycle ic (1..W+1).
  task automatic run_op(input logic [3:0] op, input int ic,
                        input logic [3:0] iop, input logic [W-1:0] id);
    logic [2*W-1:0] p;
    p = prod(a_m, b_m);
    mac_opcode = op; bus_in = '0;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk); #1;
      check($sformatf("busy_c%0d", i), mac_busy, 1);
      check($sformatf("done_c%0d", i), mac_done, (i == W + 1));
      if (i == ic) begin
        mac_opcode = iop; bus_in = id;
        model_simple(iop, id);
      end else mac_opcode = 4'd0;
    end
    @(posedge clk); #1;
    mac_opcode = 4'd0;
    model_run(op, p);
    check("busy_end", mac_busy, 0);
    check("done_end", mac_done, 0);
    check("ovf_end", mac_overflow, ovf_m);
    check("zero_end", mac_zero, (acc_m == 0));
    check("out_end", mac_out, out_m);
  endtask

  task automatic check_acc(input string tag);
    issue(4'd6, '0);
    check({tag, "_msw"}, mac_out, acc_m[2*W-1:W]);
    issue(4'd7, '0);
    check({tag, "_lsw"}, mac_out, acc_m[W-1:0]);
    check({tag, "_zero"}, mac_zero, (acc_m == 0));
    check({tag, "_ovf"}, mac_overflow, ovf_m);
  endtask

  // Start a run and abort it at busy cycle cyc via opcode or the reset pin.
  task automatic abort_run(input logic [3:0] op, input int cyc, input bit use_pin);
    mac_opcode = op;
    for (int i = 1; i <= cyc; i++) begin
      @(posedge clk); #1;
      mac_opcode = 4'd0;
      check("abort_busy", mac_busy, 1);
      check("abort_done", mac_done, 0);
    end
    if (use_pin) reset = 1'b1; else mac_opcode = 4'd8;
    @(posedge clk); #1;
    reset = 1'b0; mac_opcode = 4'd0;
    model_reset();
    check("abort_busy0", mac_busy, 0);
    check("abort_zero", mac_zero, 1);
    check("abort_out", mac_out, 0);
    check("abort_ovf", mac_overflow, 0);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", mac_done, 0);
      check("abort_idle", mac_busy, 0);
    end
  endtask

  logic [3:0] inj_ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                               4'd9, 4'd12, 4'd15};

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out", mac_out, 0);
    check("rst_busy", mac_busy, 0);
    check("rst_done", mac_done, 0);
    check("rst_zero", mac_zero, 1);
    check("rst_ovf", mac_overflow, 0);

    // 0x0F * 0x11
    issue(4'd4, 8'h0F);
    issue(4'd5, 8'h11);
    run_op(4'd1, 0, 4'd0, '0);
    check_acc("mul_0f11");

    // 0xFF * 0xFF then MAC wraps with carry; MUL clears the flag
    issue(4'd4, 8'hFF);
    issue(4'd5, 8'hFF);
    run_op(4'd1, 0, 4'd0, '0);
    run_op(4'd2, 0, 4'd0, '0);
    check_acc("mac_wrap");
    run_op(4'd1, 0, 4'd0, '0);
    check_acc("mul_clr");

    // RESET opcode then MSUB borrow
    issue(4'd8, '0);
    check("rstop_zero", mac_zero, 1);
    issue(4'd4, 8'h02);
    issue(4'd5, 8'h03);
    run_op(4'd3, 0, 4'd0, '0);
    check_acc("msub");

    // REGA during flight, ignored second MUL, A used by next MUL
    issue(4'd4, 8'h21);
    issue(4'd5, 8'h07);
    run_op(4'd1, 4, 4'd4, 8'h55);
    check_acc("inflight_a");
    run_op(4'd1, 5, 4'd1, '0);
    check_acc("new_a");
    // MSW in the ACCUM cycle captures the pre-update ACC
    run_op(4'd2, W + 1, 4'd6, '0);
    check_acc("msw_accum");

    // Aborts via opcode and via pin
    abort_run(4'd2, 5, 1'b0);
    issue(4'd4, 8'h13);
    issue(4'd5, 8'h09);
    run_op(4'd1, 0, 4'd0, '0);
    abort_run(4'd2, 5, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      issue(4'd4, W'($urandom));
      issue(4'd5, W'($urandom));
      run_op(4'($urandom_range(1, 3)), $urandom_range(0, W + 1),
             inj_ops[$urandom_range(0, 10)], W'($urandom));
      check_acc("rand");
      if (n % 4 == 3) issue(4'($urandom_range(9, 15)), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
